// File: rtl/inv_key_expansion.sv
// rtl/inv_key_expansion.sv - iterative AES-128 inverse key schedule, one round key per handshake.
// Optional INV_KEY_EMIT_FIRST_EN: emit key_in itself before walking back.
module inv_key_expansion #(
  parameter int regSize = 32,
  parameter int vecSize = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [vecSize-1:0][regSize-1:0] key_in,
  input  logic [3:0]                      round_in,
  output logic [vecSize-1:0][regSize-1:0] key_out,
  output logic [3:0]                      key_round,
  output logic                            key_valid,
  input  logic                            key_ready,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {IDLE, RUN} state_t;

  state_t                            state_q, state_d;
  logic [vecSize-1:0][regSize-1:0]   key_q, key_d;
  logic [3:0]                        round_q, round_d;
  logic                              valid_q, valid_d;
  logic                              done_q, done_d;
  logic                              err_q, err_d;

  logic [vecSize-1:0][regSize-1:0]   src_key, inv_key;
  logic [3:0]                        src_round;
  logic [31:0]                       p3, rot, sub;
  logic [7:0]                        rcon;
  logic                              round_ok;

`ifdef INV_KEY_EMIT_FIRST_EN
  assign round_ok = (round_in <= 4'd10);
`else
  assign round_ok = (round_in != 4'd0) && (round_in <= 4'd10);
`endif

  // One inverse unit shared: in IDLE it steps key_in so K[r-1] is ready one cycle after start.
  always_comb begin
    src_key   = (state_q == IDLE) ? key_in : key_q;
    src_round = (state_q == IDLE) ? round_in : round_q;
    p3        = src_key[3] ^ src_key[2];
    rot       = {p3[23:0], p3[31:24]};
    sub       = '0;
    for (int b = 0; b < 4; b++) begin
      sub[8*b +: 8] = SBOX[rot[8*b +: 8]];
    end
    case (src_round)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
    inv_key[3] = p3;
    inv_key[2] = src_key[2] ^ src_key[1];
    inv_key[1] = src_key[1] ^ src_key[0];
    inv_key[0] = src_key[0] ^ sub ^ {rcon, 24'h0};
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (round_ok) begin
            state_d = RUN;
            valid_d = 1'b1;
`ifdef INV_KEY_EMIT_FIRST_EN
            key_d   = key_in;
            round_d = round_in;
`else
            key_d   = inv_key;
            round_d = round_in - 4'd1;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (valid_q && key_ready) begin
          if (round_q != 4'd0) begin
            key_d   = inv_key;
            round_d = round_q - 4'd1;
          end else begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign key_out   = key_q;
  assign key_round = round_q;
  assign key_valid = valid_q;
  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/inv_key_expansion.md
Name: inv_key_expansion

Overview:
Iterative AES-128 inverse key schedule for the SIMD execute stage. It takes a round key K[r] in the 4 x 32-bit vector-register layout used by the forward key_expansion stage, and walks the schedule backwards: K[r-1], K[r-2], ... down to K[0], one key per accepted handshake. It feeds on-the-fly decryption (AddRoundKey in reverse round order) without storing all 11 round keys.

Parameters:
regSize, 32, width of each key word in bits (the datapath is fixed at 32).
vecSize, 4, number of words per key (AES-128 only).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request to begin a backward walk; sampled in IDLE only
key_in  input  [vecSize-1:0][regSize-1:0]  round key K[r]; word 0 = w0 (first word), word 3 = last word
round_in  input  4  index r of key_in; legal range 1..10
key_out  output  [vecSize-1:0][regSize-1:0]  emitted round key
key_round  output  4  round index of key_out
key_valid  output  1  key_out/key_round valid
key_ready  input  1  consumer accepts key_out when key_valid & key_ready
busy  output  1  high in RUN state
done  output  1  one-cycle pulse after K[0] is accepted
err  output  1  one-cycle pulse when start is seen in IDLE with round_in = 0 or round_in > 10

Behaviour:
- Reset: state = IDLE; key_out = 0; key_round = 0; key_valid = 0; busy = 0; done = 0; err = 0. Reset asserted mid-walk aborts immediately; no key is emitted after release.
- Inverse step, combinational from the held key n (round k) to p (round k-1):
  - p3 = n3^n2; p2 = n2^n1; p1 = n1^n0.
  - p0 = n0 ^ SubWord(RotWord(p3)) ^ Rcon[k-1].
  - RotWord is a left rotate by 8 bits. SubWord is the AES S-box applied per byte.
  - Rcon[0..9] = 01,02,04,08,10,20,40,80,1b,36, placed in the byte at bits 31:24. The lower bytes are 0.
- IDLE:
  - If start=1 and round_in is legal, register key_in and round_in internally, then go to RUN.
  - The first valid output is K[round_in-1], with key_valid high 1 cycle after start.
  - If start=1 and round_in is illegal, pulse err and stay in IDLE.
- RUN:
  - key_out, key_round and key_valid are held stable while key_valid=1 and key_ready=0.
  - On handshake with key_round > 0: load the inverse of key_out and set key_round-1. key_valid stays high, giving back-to-back output, 1 key per cycle when key_ready is held at 1.
  - On handshake with key_round = 0: key_valid goes to 0, done pulses in the next cycle, state returns to IDLE, and key_out retains its last value.
- start is ignored while busy=1.
- A new start is accepted in the same cycle that done is high.
- round_in = 1 produces exactly one key, K[0].
- Walk length is round_in keys, e.g. 10 keys for round_in = 10.
- The S-box is a 256-entry constant ROM, combinational, one lookup per byte. No multi-cycle lookup is used.

Optional Feature:
INV_KEY_EMIT_FIRST_EN
- Defined: the walk first emits key_in itself with key_round = round_in, then continues as above.
  - Walk length becomes round_in+1.
  - The first key_out equals key_in, 1 cycle after start.
  - round_in = 0 becomes legal and emits only key_in, then done.
- Undefined: behaviour is exactly as in Behaviour; key_in is never emitted.

Test Plan:
- FIPS-197 vector:
  - Stimulus: key_in = {d014f9a8, c9ee2589, e13f0cc8, b6630ca6}, round_in = 10, key_ready held at 1.
  - Required response: 10 consecutive valid cycles with key_round 9..0. key_round 9 = {ac7766f3, 19fadc21, 28d12941, 575c006e}; key_round 1 = {a0fafe17, 88542cb1, 23a33939, 2a6c7605}; key_round 0 = {2b7e1516, 28aed2a6, abf71588, 09cf4f3c}. done pulses once.
- Backpressure:
  - Stimulus: same vector, key_ready random 50%.
  - Required response: identical key sequence; key_out stable whenever key_valid & !key_ready; no skipped or duplicated round.
- Single step:
  - Stimulus: key_in = round-1 key above, round_in = 1.
  - Required response: only key_out = 2b7e1516 28aed2a6 abf71588 09cf4f3c, key_round 0, then done.
- Illegal rounds:
  - Stimulus: round_in = 0, then round_in = 11, with start.
  - Required response: err pulse each time; busy stays 0; key_valid stays 0 (with the macro defined, round_in = 0 emits key_in instead).
- Start while busy / reset mid-walk:
  - Stimulus: pulse start during RUN with different key_in; later deassert rst_n after 3 keys.
  - Required response: the second start has no effect; the reset drops all outputs to 0 asynchronously; after release the block is in IDLE and accepts a new start.
- Back-to-back:
  - Stimulus: assert start in the done cycle.
  - Required response: the new walk's first key_valid appears 1 cycle later, with no lost keys.
